// File: rtl/instr_encoder.sv
// Packs per-field instruction bundles into 16-bit words and emits them with a sequential program address.
// Optional saturating reject counter is enabled by defining ENC_ERR_CNT_EN.
module instr_encoder #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 restart,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           opcode,
    input  logic [1:0]           op,
    input  logic [2:0]           rn,
    input  logic [2:0]           rd,
    input  logic [2:0]           rm,
    input  logic [1:0]           shift,
    input  logic [15:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [15:0] word_c;
    logic        illegal_c, range_c, reject_c;
    logic        imm8_ok, imm5_ok;
    logic        accept_c, xfer_c;

    // Sign-extension check: all bits above the field must match its sign bit.
    assign imm8_ok = (imm[15:7] == '0) || (imm[15:7] == '1);
    assign imm5_ok = (imm[15:4] == '0) || (imm[15:4] == '1);

    always_comb begin
        word_c    = {opcode, op, 11'b0};
        illegal_c = 1'b0;
        range_c   = 1'b0;
        case (opcode)
            3'b000: illegal_c = 1'b1;
            3'b001: begin
                word_c[10:0] = {rn, imm[7:0]};
                range_c      = !imm8_ok;
            end
            3'b010: begin
                if (op == 2'b11) begin
                    word_c[10:0] = {rn, imm[7:0]};
                    range_c      = !imm8_ok;
                end else begin
                    word_c[10:0] = {rn, rd, 2'b00, rm};
                end
            end
            3'b011, 3'b100: begin
                word_c[10:0] = {rn, rd, imm[4:0]};
                range_c      = !imm5_ok;
            end
            3'b101: word_c[10:0] = {rn, rd, shift, rm};
            3'b110: begin
                case (op)
                    2'b10: begin
                        word_c[10:0] = {rn, imm[7:0]};
                        range_c      = !imm8_ok;
                    end
                    2'b00:   word_c[10:0] = {3'b000, rd, shift, rm};
                    default: illegal_c = 1'b1;
                endcase
            end
            default: word_c[10:0] = 11'b0;
        endcase
        reject_c = illegal_c || range_c;
    end

    // valid/ready: a transfer happens on any edge where valid and ready are both high;
    // the producer holds its data stable until then, and ready never depends on valid.
    assign in_ready = !out_valid_q || out_ready;
    assign accept_c = in_valid && in_ready && !restart;
    assign xfer_c   = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        if (xfer_c) begin
            out_valid_d = 1'b0;
            out_addr_d  = out_addr_q + 1'b1;
        end
        if (accept_c) begin
            if (reject_c) begin
                err_d      = 1'b1;
                err_code_d = illegal_c ? 2'b01 : 2'b10;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = word_c;
            end
        end
        if (restart) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_addr_d  = BASE;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= BASE;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

`ifdef ENC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept_c && reject_c && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed test-plan sequence plus randomized traffic against a field-level model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        resetn, restart, in_valid, out_ready;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, shift;
  logic [15:0] imm;
  logic        in_ready, out_valid, err;
  logic [15:0] out_data;
  logic [7:0]  out_addr;
  logic [1:0]  err_code;
  logic [7:0]  err_cnt;
  logic        in_ready2, out_valid2, err2;
  logic [15:0] out_data2;
  logic [1:0]  out_addr2, err_code2;
  logic [7:0]  err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .ERR_CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .err(err), .err_code(err_code), .err_cnt(err_cnt)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0), .ERR_CNT_W(8)) dut_w (
    .clk(clk), .resetn(resetn), .restart(restart), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_addr(out_addr2),
    .err(err2), .err_code(err_code2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Field-level reference: word value and error code (0 ok, 1 illegal, 2 range)
  function automatic void model_enc(input int opc, input int opf, input int frn, input int frd,
                                    input int frm, input int fsh, input logic [15:0] fimm,
                                    output int word, output int code);
    int iv;
    iv   = int'($signed(fimm));
    word = opc * 8192 + opf * 2048;
    code = 0;
    case (opc)
      0: code = 1;
      1: begin
        word += frn * 256 + ((iv % 256) + 256) % 256;
        if (iv < -128 || iv > 127) code = 2;
      end
      2: begin
        if (opf == 3) begin
          word += frn * 256 + ((iv % 256) + 256) % 256;
          if (iv < -128 || iv > 127) code = 2;
        end else begin
          word += frn * 256 + frd * 32 + frm;
        end
      end
      3, 4: begin
        word += frn * 256 + frd * 32 + ((iv % 32) + 32) % 32;
        if (iv < -16 || iv > 15) code = 2;
      end
      5: word += frn * 256 + frd * 32 + fsh * 8 + frm;
      6: begin
        if (opf == 2) begin
          word += frn * 256 + ((iv % 256) + 256) % 256;
          if (iv < -128 || iv > 127) code = 2;
        end else if (opf == 0) begin
          word += frd * 32 + fsh * 8 + frm;
        end else begin
          code = 1;
        end
      end
      default: ;
    endcase
  endfunction

  // Behavioural model state, advanced on each rising edge from the stimulus
  bit model_ok = 1'b0;
  int m_valid, m_data, m_addr, m_err, m_code, m_cnt;

  always @(posedge clk) begin
    int w, c;
    bit acc, xfer;
    if (!resetn) begin
      m_valid = 0; m_data = 0; m_addr = 0; m_err = 0; m_code = 0; m_cnt = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      acc  = in_valid && (m_valid == 0 || out_ready) && !restart;
      xfer = (m_valid != 0) && out_ready;
      m_err = 0;
      if (restart) begin
        m_valid = 0; m_data = 0; m_addr = 0;
      end else begin
        if (xfer) begin
          m_valid = 0;
          m_addr  = (m_addr + 1) % 256;
        end
        if (acc) begin
          model_enc(opcode, op, rn, rd, rm, shift, imm, w, c);
          if (c != 0) begin
            m_err  = 1;
            m_code = c;
            if (m_cnt < 255) m_cnt++;
          end else begin
            m_valid = 1;
            m_data  = w;
          end
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    #1;
    if (model_ok && resetn) begin
      chk("out_valid", 32'(out_valid), m_valid);
      if (m_valid != 0) chk("out_data", 32'(out_data), m_data);
      chk("out_addr", 32'(out_addr), m_addr);
      chk("err", 32'(err), m_err);
      chk("err_code", 32'(err_code), m_code);
      chk("in_ready", 32'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
`ifdef ENC_ERR_CNT_EN
      chk("err_cnt", 32'(err_cnt), m_cnt);
`else
      chk("err_cnt", 32'(err_cnt), 0);
`endif
      chk("w_out_valid", 32'(out_valid2), m_valid);
      if (m_valid != 0) chk("w_out_data", 32'(out_data2), m_data);
      chk("w_out_addr", 32'(out_addr2), m_addr % 4);
    end
  end

  task automatic set_in(input bit v, input logic [2:0] f_opc, input logic [1:0] f_op,
                        input logic [2:0] f_rn, input logic [2:0] f_rd, input logic [2:0] f_rm,
                        input logic [1:0] f_sh, input logic [15:0] f_imm);
    in_valid = v; opcode = f_opc; op = f_op; rn = f_rn; rd = f_rd; rm = f_rm;
    shift = f_sh; imm = f_imm;
  endtask

  task automatic idle();
    set_in(1'b0, 3'd7, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
  endtask

  task automatic halt();
    set_in(1'b1, 3'd7, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
  endtask

  initial begin
    int w, c, r;
    resetn = 1'b0; restart = 1'b0; out_ready = 1'b1;
    idle();

    // Pin the reference model with hand-computed words
    model_enc(6, 2, 3, 0, 0, 0, 16'hFFFB, w, c);
    chk("pin_mov", w, 32'hD3FB);
    model_enc(5, 0, 1, 2, 0, 1, 16'h7FFF, w, c);
    chk("pin_add", w, 32'hA148);
    model_enc(3, 0, 6, 5, 0, 0, 16'd3, w, c);
    chk("pin_ldr", w, 32'h66A3);
    model_enc(3, 0, 6, 5, 0, 0, 16'd16, w, c);
    chk("pin_ldr_range", c, 2);

    repeat (2) @(negedge clk);
    @(negedge clk); resetn = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    @(negedge clk); set_in(1'b1, 3'd6, 2'd2, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB);
    @(negedge clk); set_in(1'b1, 3'd5, 2'd0, 3'd1, 3'd2, 3'd0, 2'd1, 16'h7FFF);
    #1;
    chk("mov_data", 32'(out_data), 32'hD3FB);
    chk("mov_addr", 32'(out_addr), 0);
    @(negedge clk); set_in(1'b1, 3'd3, 2'd0, 3'd6, 3'd5, 3'd0, 2'd0, 16'd3);
    #1;
    chk("add_data", 32'(out_data), 32'hA148);
    chk("add_addr", 32'(out_addr), 1);
    chk("add_err", 32'(err), 0);
    @(negedge clk); set_in(1'b1, 3'd3, 2'd0, 3'd6, 3'd5, 3'd0, 2'd0, 16'd16);
    #1;
    chk("ldr_data", 32'(out_data), 32'h66A3);
    chk("ldr_addr", 32'(out_addr), 2);
    @(negedge clk); idle();
    #1;
    chk("rej_err", 32'(err), 1);
    chk("rej_code", 32'(err_code), 2);
    chk("rej_valid", 32'(out_valid), 0);
    chk("rej_addr", 32'(out_addr), 3);
`ifdef ENC_ERR_CNT_EN
    chk("rej_cnt", 32'(err_cnt), 1);
`endif
    @(negedge clk); idle();
    #1;
    chk("rej_err_pulse", 32'(err), 0);

    // Backpressure then a 4-cycle full-rate stream
    @(negedge clk); halt(); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_data", 32'(out_data), 32'hE000);
      chk("bp_addr", 32'(out_addr), 3);
    end
    @(negedge clk); out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk); idle();
    @(negedge clk);
    #1;
    chk("stream_addr", 32'(out_addr), 8);

    // Restart mid-handshake keeps err_code
    @(negedge clk); halt(); out_ready = 1'b0;
    @(negedge clk); idle();
    #1;
    chk("held_valid", 32'(out_valid), 1);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    #1;
    chk("rs_valid", 32'(out_valid), 0);
    chk("rs_addr", 32'(out_addr), 0);
    chk("rs_code", 32'(err_code), 2);
`ifdef ENC_ERR_CNT_EN
    chk("rs_cnt", 32'(err_cnt), 1);
`endif

    // Reset mid-handshake clears everything
    @(negedge clk); halt();
    @(negedge clk); idle();
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    #1;
    chk("rr_valid", 32'(out_valid), 0);
    chk("rr_addr", 32'(out_addr), 0);
    chk("rr_code", 32'(err_code), 0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      opcode   = 3'($urandom_range(0, 7));
      op       = 2'($urandom_range(0, 3));
      rn       = 3'($urandom_range(0, 7));
      rd       = 3'($urandom_range(0, 7));
      rm       = 3'($urandom_range(0, 7));
      shift    = 2'($urandom_range(0, 3));
      r        = $urandom_range(0, 3);
      if (r == 0) imm = 16'($urandom_range(0, 65535));
      else        imm = 16'(int'($urandom_range(0, 300)) - 150);
      out_ready = ($urandom_range(0, 2) != 0);
      restart   = ($urandom_range(0, 149) == 0);
      resetn    = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk); idle(); restart = 1'b0; resetn = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
